// File: rtl/hs_tx_pkg.sv
// hs_tx shared types and defaults.
// Holds the handshake FSM state encoding.
package hs_tx_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;
  localparam int SYNC_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } hs_state_t;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Multi-flop synchronizer for a single async level.
// Cleared by the synchronous reset.
module cdc_sync2 #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/hs_tx.sv
// FIFO-buffered four-phase req/ack transmitter.
// Words leave through data_o under a req/ack handshake.
module hs_tx
  import hs_tx_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       s_vld,
  output logic                       s_rdy,
  input  logic [DW-1:0]              s_data,
  output logic                       req_o,
  output logic [DW-1:0]              data_o,
  input  logic                       ack_i,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  hs_state_t       state;
  logic            ack_s;
  logic [AW:0]     wptr;
  logic [AW:0]     rptr;
  logic [LW-1:0]   level;
  logic [DW-1:0]   mem [DEPTH];
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  cdc_sync2 #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d    (ack_i),
    .q    (ack_s)
  );

  // wrap bit makes wptr - rptr the true occupancy
  assign level = LW'(wptr - rptr);
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign s_rdy = !full;
  assign push  = s_vld && s_rdy;
  assign pop   = (state == IDLE) && !empty && !ack_s;

  assign level_o = level;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      req_o  <= 1'b0;
      data_o <= '0;
      busy_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            data_o <= mem[rptr[AW-1:0]];
            busy_o <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          req_o <= 1'b1;
          state <= REQ;
        end
        REQ: begin
          if (ack_s) begin
            req_o <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          req_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
